// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared funct3 encodings, FSM states and request decode helpers
package mem_bus_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    // Stores only know B/H/W; loads additionally know the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core data bus between the RV32I core and the data memory
interface data_mem_responder_if;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [2:0]  busFunct3;
    logic [31:0] busRData;
    logic        busReady;
    logic        busErr;

    modport master (
        output busReq, busWe, busAddr, busWData, busFunct3,
        input  busRData, busReady, busErr
    );

    modport slave (
        input  busReq, busWe, busAddr, busWData, busFunct3,
        output busRData, busReady, busErr
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane select/extension for loads
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Replicate store data across lanes so the enables alone pick the target lanes;
    // pick and extend the load lane from the full RAM word.
    always_comb begin
        byte_en = 4'b0000;
        wword   = wdata;
        rdata   = 32'h0;
        case (addr)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = addr[1] ? rword[31:16] : rword[15:0];

        case (funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr;
                wword   = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en = addr[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase

        case (funct3)
            F3_B:    rdata = {{24{rbyte[7]}}, rbyte};
            F3_H:    rdata = {{16{rhalf[15]}}, rhalf};
            F3_W:    rdata = rword;
            F3_BU:   rdata = {24'h0, rbyte};
            F3_HU:   rdata = {16'h0, rhalf};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data bus responder: word RAM with wait states and error flagging
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_responder_if.slave bus
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         AW        = IDX_W + 2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q;

    logic        req_we_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [2:0]  req_f3_q;

    logic [31:0] ram [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic        err_q;

    logic             accept;
    logic             commit;
    logic             op_we;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [2:0]       op_f3;
    logic             op_err;
    logic [IDX_W-1:0] op_idx;
    logic [3:0]       byte_en;
    logic [31:0]      wword;
    logic [31:0]      ldata;

    // With zero wait states the RAM access happens on the accepting edge, so the
    // live bus inputs are used in IDLE; otherwise the captured request is used.
    always_comb begin
        op_we    = (state_q == IDLE) ? bus.busWe     : req_we_q;
        op_addr  = (state_q == IDLE) ? bus.busAddr   : req_addr_q;
        op_wdata = (state_q == IDLE) ? bus.busWData  : req_wdata_q;
        op_f3    = (state_q == IDLE) ? bus.busFunct3 : req_f3_q;
        op_idx   = op_addr[AW-1:2];
        op_err   = (op_addr[31:AW] != BASE_ADDR[31:AW])
                 || !f3_legal(op_we, op_f3)
                 || misaligned(op_f3, op_addr[1:0]);
        accept   = (state_q == IDLE) && bus.busReq;
        commit   = (state_d == RESP) && !reset;
    end

    // Next-state: one accept, optional wait window, single response cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.busReq) state_d = NO_WAIT ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Wait counter: loaded on accept, counts down through WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= WAIT_LOAD;
        end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Request capture so the master may change its lines after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            req_f3_q    <= 3'b000;
        end else if (accept) begin
            req_we_q    <= bus.busWe;
            req_addr_q  <= bus.busAddr;
            req_wdata_q <= bus.busWData;
            req_f3_q    <= bus.busFunct3;
        end
    end

    // Byte-enabled store on the edge entering RESP; erroneous requests never write.
    always_ff @(posedge clk) begin
        if (commit && op_we && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) ram[op_idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    mem_lane_align u_align (
        .addr    (op_addr[1:0]),
        .funct3  (op_f3),
        .wdata   (op_wdata),
        .rword   (ram[op_idx]),
        .byte_en (byte_en),
        .wword   (wword),
        .rdata   (ldata)
    );

    // Response data/error registered on entry to RESP and zero at all other times.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= (op_err || op_we) ? 32'h0 : ldata;
            err_q   <= op_err;
        end else begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end
    end

    assign bus.busReady = (state_q == RESP);
    assign bus.busRData = rdata_q;
    assign bus.busErr   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - bench for data_mem_responder with 2 and 0 wait states
module tb_data_mem_responder;
    import mem_bus_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    bit          sel;
    logic        req, we_i;
    logic [31:0] addr_i, wd_i;
    logic [2:0]  f3_i;
    logic        rdy, er;
    logic [31:0] rd;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [2][1024];

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    assign bus2.busReq    = req & ~sel;
    assign bus0.busReq    = req & sel;
    assign bus2.busWe     = we_i;
    assign bus0.busWe     = we_i;
    assign bus2.busAddr   = addr_i;
    assign bus0.busAddr   = addr_i;
    assign bus2.busWData  = wd_i;
    assign bus0.busWData  = wd_i;
    assign bus2.busFunct3 = f3_i;
    assign bus0.busFunct3 = f3_i;
    assign rdy = sel ? bus0.busReady : bus2.busReady;
    assign rd  = sel ? bus0.busRData : bus2.busRData;
    assign er  = sel ? bus0.busErr   : bus2.busErr;

    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );
    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-addressed memory model: returns {err, load value} and applies legal stores.
    function automatic logic [32:0] model_txn(input bit s, input bit we, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [2:0] f3);
        int          size;
        int          off;
        bit          inr, legal, aligned;
        logic [31:0] v;
        inr = (addr >= BASE) && (addr < BASE + 32'd1024);
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        legal   = we ? (f3 <= 3'd2) : (size != 0 && f3 != 3'd6);
        aligned = (size != 0) && ((addr & 32'(size - 1)) == 32'd0);
        if (!(inr && legal && aligned)) return {1'b1, 32'h0};
        off = int'(addr - BASE);
        if (we) begin
            for (int i = 0; i < size; i++) mem[int'(s)][off + i] = wdata[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem[int'(s)][off + i];
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        return {1'b0, v};
    endfunction

    // One transaction: drive, accept, scramble the lines, wait for the response pulse.
    task automatic txn(input string tag, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input bit hold, output logic [31:0] got);
        logic [32:0] e;
        int          lat;
        int          w;
        w = sel ? 0 : 2;
        e = model_txn(sel, we, addr, wdata, f3);
        @(negedge clk);
        req = 1'b1; we_i = we; addr_i = addr; wd_i = wdata; f3_i = f3;
        @(posedge clk); #1;
        req = hold; we_i = 1'($urandom); addr_i = $urandom; wd_i = $urandom; f3_i = 3'($urandom);
        lat = 0;
        while (!rdy && lat < 40) begin
            check({tag, "/wait_rdata"}, rd, 32'h0);
            check({tag, "/wait_err"}, {31'b0, er}, 32'h0);
            @(posedge clk); #1;
            lat++;
        end
        req = 1'b0;
        check({tag, "/latency"}, 32'(lat), 32'(w));
        check({tag, "/rdata"}, rd, e[31:0]);
        check({tag, "/err"}, {31'b0, er}, {31'b0, e[32]});
        got = rd;
        @(posedge clk); #1;
        check({tag, "/pulse_end"}, {31'b0, rdy}, 32'h0);
        check({tag, "/rdata_zero"}, rd, 32'h0);
    endtask

    initial begin
        logic [31:0] got;
        logic [32:0] e;
        logic [31:0] a;
        int          n_rdy;
        int          r;

        reset = 1'b1; sel = 1'b0; req = 1'b0; we_i = 1'b0;
        addr_i = 32'h0; wd_i = 32'h0; f3_i = 3'b000;
        #12;
        check("reset/ready2", {31'b0, bus2.busReady}, 32'h0);
        check("reset/rdata2", bus2.busRData, 32'h0);
        check("reset/err2", {31'b0, bus2.busErr}, 32'h0);
        check("reset/ready0", {31'b0, bus0.busReady}, 32'h0);
        check("reset/rdata0", bus0.busRData, 32'h0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 16; i++) txn("init", 1'b1, BASE + 32'(4*i), $urandom, F3_W, 1'b0, got);

        txn("sw8", 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, F3_W, 1'b0, got);
        txn("lw8", 1'b0, BASE + 32'd8, 32'h0, F3_W, 1'b0, got);
        check("plan/lw8", got, 32'hDEAD_BEEF);

        txn("sb9", 1'b1, BASE + 32'd9, 32'h0000_0080, F3_B, 1'b0, got);
        txn("lb9", 1'b0, BASE + 32'd9, 32'h0, F3_B, 1'b0, got);
        check("plan/lb9", got, 32'hFFFF_FF80);
        txn("lbu9", 1'b0, BASE + 32'd9, 32'h0, F3_BU, 1'b0, got);
        check("plan/lbu9", got, 32'h0000_0080);
        txn("lw8b", 1'b0, BASE + 32'd8, 32'h0, F3_W, 1'b0, got);
        check("plan/word8", got, 32'hDEAD_80EF);

        txn("sh14", 1'b1, BASE + 32'd14, 32'h0000_8001, F3_H, 1'b0, got);
        txn("lh14", 1'b0, BASE + 32'd14, 32'h0, F3_H, 1'b0, got);
        check("plan/lh14", got, 32'hFFFF_8001);
        txn("lhu14", 1'b0, BASE + 32'd14, 32'h0, F3_HU, 1'b0, got);
        check("plan/lhu14", got, 32'h0000_8001);
        txn("lw12", 1'b0, BASE + 32'd12, 32'h0, F3_W, 1'b0, got);
        check("plan/lw12_upper", {16'h0, got[31:16]}, 32'h0000_8001);

        txn("err_lw2", 1'b0, BASE + 32'd2, 32'h0, F3_W, 1'b0, got);
        txn("err_sh3", 1'b1, BASE + 32'd3, 32'h1111_2222, F3_H, 1'b0, got);
        txn("err_lbm1", 1'b0, BASE - 32'd1, 32'h0, F3_B, 1'b0, got);
        txn("err_swtop", 1'b1, BASE + 32'd1024, 32'h3333_4444, F3_W, 1'b0, got);
        txn("err_f3_011", 1'b0, BASE + 32'd0, 32'h0, 3'b011, 1'b0, got);
        txn("err_sb_f3_4", 1'b1, BASE + 32'd0, 32'h5555_6666, 3'b100, 1'b0, got);
        txn("rb0", 1'b0, BASE + 32'd0, 32'h0, F3_W, 1'b0, got);
        txn("rb4", 1'b0, BASE + 32'd4, 32'h0, F3_W, 1'b0, got);

        txn("hold_sw20", 1'b1, BASE + 32'd20, 32'h0BAD_CAFE, F3_W, 1'b1, got);
        txn("hold_lw20", 1'b0, BASE + 32'd20, 32'h0, F3_W, 1'b0, got);

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = BASE - 32'd1 - 32'($urandom_range(0, 7));
            else if (r == 1) a = BASE + 32'd1024 + 32'($urandom_range(0, 7));
            else             a = BASE + 32'($urandom_range(0, 63));
            txn("rand", 1'($urandom), a, $urandom, 3'($urandom), 1'($urandom), got);
        end

        txn("rst_pre", 1'b1, BASE + 32'd4, 32'h1234_5678, F3_W, 1'b0, got);
        @(negedge clk);
        req = 1'b1; we_i = 1'b1; addr_i = BASE + 32'd4; wd_i = 32'hCAFE_F00D; f3_i = F3_W;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #2; reset = 1'b1;
        #1;
        check("rst/ready", {31'b0, rdy}, 32'h0);
        check("rst/rdata", rd, 32'h0);
        check("rst/err", {31'b0, er}, 32'h0);
        @(posedge clk); #1;
        check("rst/ready_held", {31'b0, rdy}, 32'h0);
        @(negedge clk); reset = 1'b0;
        txn("rst_lw4", 1'b0, BASE + 32'd4, 32'h0, F3_W, 1'b0, got);
        check("rst/old_value", got, 32'h1234_5678);

        sel = 1'b1;
        e = model_txn(sel, 1'b1, BASE + 32'd16, 32'hA5A5_5A5A, F3_W);
        @(negedge clk);
        req = 1'b1; we_i = 1'b1; addr_i = BASE + 32'd16; wd_i = 32'hA5A5_5A5A; f3_i = F3_W;
        n_rdy = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check("w0/pattern", {31'b0, rdy}, 32'(k % 2));
            check("w0/err", {31'b0, er}, {31'b0, e[32]});
            n_rdy += int'(rdy);
        end
        req = 1'b0;
        check("w0/count", 32'(n_rdy), 32'd4);
        txn("w0_lw16", 1'b0, BASE + 32'd16, 32'h0, F3_W, 1'b0, got);
        check("w0/lw16", got, 32'hA5A5_5A5A);
        txn("w0_lhu18", 1'b0, BASE + 32'd18, 32'h0, F3_HU, 1'b0, got);
        txn("w0_err", 1'b0, BASE + 32'd17, 32'h0, F3_H, 1'b0, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
